// File: rtl/key_pulse_gen.sv
// Push-button conditioner: synchronise, debounce and emit one-cycle press pulses on sw.
// Define KEY_AUTO_REPEAT_EN to add hold-to-repeat on the cursor keys (bits 0 and 3).
module key_pulse_gen #(
  parameter int N_KEYS          = 5,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 15,
  parameter bit KEY_ACTIVE_LOW  = 1'b1,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_PERIOD   = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] sw,
  output logic [N_KEYS-1:0] key_level,
  output logic              busy
);

  localparam int MODE_KEY = 4;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [N_KEYS-1:0] MODE_MASK = N_KEYS'(1) << MODE_KEY;

  if (N_KEYS <= MODE_KEY) begin : g_bad_keys
    $error("key_pulse_gen: N_KEYS must cover the MODE key at bit 4");
  end
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES >= (1 << CNT_W)) begin : g_bad_debounce
    $error("key_pulse_gen: DEBOUNCE_CYCLES must be >= 2 and fit in CNT_W bits");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("key_pulse_gen: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  typedef enum logic {
    STABLE_IDLE = 1'b0,
    COUNTING    = 1'b1
  } state_t;

  logic [N_KEYS-1:0] key_in;
  logic [N_KEYS-1:0] sync_p0;
  logic [N_KEYS-1:0] sync_p1;

  state_t            state     [N_KEYS];
  state_t            state_nxt [N_KEYS];
  logic [CNT_W-1:0]  cnt       [N_KEYS];
  logic [CNT_W-1:0]  cnt_nxt   [N_KEYS];
  logic [N_KEYS-1:0] stable;
  logic [N_KEYS-1:0] stable_nxt;
  logic [N_KEYS-1:0] cnt_nz;

  logic [N_KEYS-1:0] stable_p1;
  logic [N_KEYS-1:0] rise;
  logic [N_KEYS-1:0] rise_p1;
  logic [N_KEYS-1:0] pulse_p1;

  // Fold pad polarity so everything downstream is active-high.
  assign key_in = KEY_ACTIVE_LOW ? ~key_raw : key_raw;

  // Stage p0/p1: two-flop synchroniser; sync_p1 is the synchronised level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= key_in;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: per-key state, counter and accepted level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_KEYS; i++) begin
        state[i] <= STABLE_IDLE;
        cnt[i]   <= '0;
      end
      stable <= '0;
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
      stable <= stable_nxt;
    end
  end

  always_comb begin
    stable_nxt = stable;
    cnt_nz     = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      cnt_nz[i]    = (cnt[i] != '0);
      case (state[i])
        STABLE_IDLE: begin
          if (sync_p1[i] != stable[i]) begin
            state_nxt[i] = COUNTING;
            cnt_nxt[i]   = CNT_W'(1);
          end
        end
        COUNTING: begin
          if (sync_p1[i] == stable[i]) begin
            // Input bounced back before the window closed: discard the attempt.
            state_nxt[i] = STABLE_IDLE;
            cnt_nxt[i]   = '0;
          end else if (cnt[i] == CNT_LAST) begin
            state_nxt[i]  = STABLE_IDLE;
            cnt_nxt[i]    = '0;
            stable_nxt[i] = sync_p1[i];
          end else begin
            cnt_nxt[i] = cnt[i] + CNT_W'(1);
          end
        end
        default: begin
          state_nxt[i] = STABLE_IDLE;
          cnt_nxt[i]   = '0;
        end
      endcase
    end
  end

  assign rise = stable & ~stable_p1;

  // Stage p1 (edge detect): press rises are captured; releases never pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_p1 <= '0;
      rise_p1   <= '0;
      busy      <= 1'b0;
    end else begin
      stable_p1 <= stable;
      rise_p1   <= rise;
      busy      <= |cnt_nz;
    end
  end

`ifdef KEY_AUTO_REPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

  logic [N_KEYS-1:0] rep_p1;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_rep
    if (i == 0 || i == 3) begin : g_cursor
      logic [HOLD_W-1:0] hold_cnt;
      logic              hold_on;
      logic              repeating;
      logic              rep;

      // Hold timer aligned with rise_p1 so repeats land exactly DELAY/PERIOD after the press pulse.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          hold_cnt  <= '0;
          hold_on   <= 1'b0;
          repeating <= 1'b0;
          rep       <= 1'b0;
        end else if (!stable[i]) begin
          hold_cnt  <= '0;
          hold_on   <= 1'b0;
          repeating <= 1'b0;
          rep       <= 1'b0;
        end else if (rise[i]) begin
          hold_cnt  <= '0;
          hold_on   <= 1'b1;
          repeating <= 1'b0;
          rep       <= 1'b0;
        end else if (hold_on) begin
          if (hold_cnt == (repeating ? PERIOD_LAST : DELAY_LAST)) begin
            hold_cnt  <= '0;
            repeating <= 1'b1;
            rep       <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
            rep      <= 1'b0;
          end
        end else begin
          rep <= 1'b0;
        end
      end

      assign rep_p1[i] = rep;
    end else begin : g_none
      assign rep_p1[i] = 1'b0;
    end
  end

  assign pulse_p1 = rise_p1 | rep_p1;
`else
  assign pulse_p1 = rise_p1;
`endif

  // Stage p2 (output): MODE wins over any coincident pulse so a cursor move never hits the wrong mode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw        <= '0;
      key_level <= '0;
    end else begin
      sw        <= pulse_p1[MODE_KEY] ? MODE_MASK : pulse_p1;
      key_level <= stable_p1;
    end
  end

endmodule

// File: tb/tb_key_pulse_gen.sv
// Directed bench for key_pulse_gen with DEBOUNCE_CYCLES=4 (press pulse at edge 7).
// Expectations for held cursor keys follow KEY_AUTO_REPEAT_EN when it is defined.
module tb_key_pulse_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] key_raw = 5'h1F;
  logic [4:0] sw;
  logic [4:0] key_level;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  key_pulse_gen #(
    .N_KEYS          (5),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (15),
    .KEY_ACTIVE_LOW  (1'b1),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_raw   (key_raw),
    .sw        (sw),
    .key_level (key_level),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_all(input bit chk);
    key_raw = 5'h1F;
    for (int k = 0; k < 12; k++) begin
      step();
      if (chk) begin
        n_checks++;
        if (sw !== 5'b0) $display("FAIL release_no_pulse k=%0d got sw=%b want 00000", k, sw);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    key_raw = 5'h1F;
    repeat (3) step();
    n_checks++;
    if (sw !== 5'b0) $display("FAIL reset_sw got %b want 00000", sw); else n_pass++;
    n_checks++;
    if (key_level !== 5'b0) $display("FAIL reset_level got %b want 00000", key_level); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    rst = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_single_press();
    key_raw[4] = 1'b0;
    for (int k = 0; k < 13; k++) begin
      step();
      n_checks++;
      if (sw[4] !== (k == 7)) $display("FAIL press_sw4 k=%0d got %b want %b", k, sw[4], (k == 7));
      else n_pass++;
      n_checks++;
      if (key_level[4] !== (k >= 7)) $display("FAIL press_level4 k=%0d got %b want %b", k, key_level[4], (k >= 7));
      else n_pass++;
      n_checks++;
      if (sw[3:0] !== 4'b0) $display("FAIL press_others k=%0d got %b want 0000", k, sw[3:0]);
      else n_pass++;
    end
    release_all(1'b1);
    n_checks++;
    if (key_level !== 5'b0) $display("FAIL release_level got %b want 00000", key_level); else n_pass++;
  endtask

  task automatic test_bounce();
    bit seen_busy = 1'b0;
    for (int k = 0; k < 20; k++) begin
      key_raw[0] = (k < 3) ? 1'b0 : (k == 3) ? 1'b1 : (k < 6) ? 1'b0 : 1'b1;
      step();
      if (busy) seen_busy = 1'b1;
      n_checks++;
      if (sw[0] !== 1'b0) $display("FAIL bounce_sw0 k=%0d got %b want 0", k, sw[0]); else n_pass++;
      n_checks++;
      if (key_level[0] !== 1'b0) $display("FAIL bounce_level0 k=%0d got %b want 0", k, key_level[0]); else n_pass++;
    end
    n_checks++;
    if (seen_busy !== 1'b1) $display("FAIL bounce_busy_seen got %b want 1", seen_busy); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL bounce_busy_idle got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_mode_priority();
    key_raw[0] = 1'b0;
    key_raw[4] = 1'b0;
    for (int k = 0; k < 9; k++) begin
      step();
      n_checks++;
      if (sw[4] !== (k == 7)) $display("FAIL prio_sw4 k=%0d got %b want %b", k, sw[4], (k == 7));
      else n_pass++;
      n_checks++;
      if (sw[0] !== 1'b0) $display("FAIL prio_sw0 k=%0d got %b want 0", k, sw[0]); else n_pass++;
      n_checks++;
      if (key_level[0] !== (k >= 7)) $display("FAIL prio_level0 k=%0d got %b want %b", k, key_level[0], (k >= 7));
      else n_pass++;
    end
    release_all(1'b1);
  endtask

  task automatic test_dual_cursor();
    key_raw[0] = 1'b0;
    key_raw[3] = 1'b0;
    for (int k = 0; k < 9; k++) begin
      step();
      n_checks++;
      if (sw[0] !== (k == 7)) $display("FAIL dual_sw0 k=%0d got %b want %b", k, sw[0], (k == 7));
      else n_pass++;
      n_checks++;
      if (sw[3] !== (k == 7)) $display("FAIL dual_sw3 k=%0d got %b want %b", k, sw[3], (k == 7));
      else n_pass++;
    end
    release_all(1'b1);
  endtask

  task automatic test_reset_mid_hold();
    key_raw[2] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      n_checks++;
      if (sw[2] !== (k == 7)) $display("FAIL hold2_sw2 k=%0d got %b want %b", k, sw[2], (k == 7));
      else n_pass++;
    end
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({sw, key_level, busy} !== 11'b0)
        $display("FAIL in_reset k=%0d got sw=%b level=%b busy=%b want all 0", k, sw, key_level, busy);
      else n_pass++;
      if (k < 2) step();
    end
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      n_checks++;
      if (sw[2] !== (k == 7)) $display("FAIL after_reset_sw2 k=%0d got %b want %b", k, sw[2], (k == 7));
      else n_pass++;
      n_checks++;
      if (key_level[2] !== (k >= 7)) $display("FAIL after_reset_level2 k=%0d got %b want %b", k, key_level[2], (k >= 7));
      else n_pass++;
    end
    release_all(1'b1);
  endtask

  task automatic test_hold();
    bit exp;
    key_raw[3] = 1'b0;
    for (int k = 0; k < 35; k++) begin
      step();
`ifdef KEY_AUTO_REPEAT_EN
      exp = (k == 7) || (k == 17) || (k == 22) || (k == 27) || (k == 32);
`else
      exp = (k == 7);
`endif
      n_checks++;
      if (sw[3] !== exp) $display("FAIL hold_sw3 k=%0d got %b want %b", k, sw[3], exp);
      else n_pass++;
    end
`ifdef KEY_AUTO_REPEAT_EN
    release_all(1'b0);
`else
    release_all(1'b1);
`endif
    key_raw[4] = 1'b0;
    for (int k = 0; k < 35; k++) begin
      step();
      n_checks++;
      if (sw[4] !== (k == 7)) $display("FAIL hold_sw4 k=%0d got %b want %b", k, sw[4], (k == 7));
      else n_pass++;
    end
    release_all(1'b1);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_mode_priority();
    test_dual_cursor();
    test_reset_mid_hold();
    test_hold();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
